// File: rtl/mux_nbit_rr.sv
// Registered N-channel, W-bit valid/ready multiplexer with fixed-select and
// round-robin grant modes; one output register stage, one cycle of latency.
module mux_nbit_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    input  logic                      rr_en,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic            load;
    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SELW-1:0] last;
    int              idx;

    // Output register is empty or being drained this cycle, so it can take a word.
    assign load = ~out_valid | out_ready;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (rr_en) begin
            // Scan from the channel after the last one served, wrapping once.
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = int'(last) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!grant_valid && in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(idx);
                end
            end
        end else begin
            // An out-of-range select matches no channel and simply never grants.
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end
    end

    // Data mux kept separate from the grant so in_ready never depends on in_data.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = ~reset & load & grant_valid & (grant_idx == SELW'(i));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= SELW'(CHANNELS - 1);
        end else if (load) begin
            if (grant_valid) begin
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                out_valid <= 1'b1;
                last      <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_nbit_rr.md
# mux_nbit_rr

Registered N-channel, W-bit multiplexer with a valid/ready handshake on every input and on the output. It generalises the 1-bit two-input select mux into a parametrised channel selector with two modes: fixed select or fair round-robin arbitration. A single output register stage gives one cycle of latency, so upstream producers can share one downstream consumer.

## Interface
- WIDTH, 8, data bits per channel (>= 1)
- CHANNELS, 4, number of input channels (>= 2)
- SELW, $clog2(CHANNELS), width of the select and channel-index fields (derived; do not override)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ready  output  CHANNELS  per-channel accept; combinational; at most one bit high
- sel  input  SELW  channel index used in fixed mode
- rr_en  input  1  0 = fixed mode (use sel); 1 = round-robin mode
- out_data  output  WIDTH  registered selected data
- out_chan  output  SELW  registered index of the channel that produced out_data
- out_valid  output  1  output register holds data
- out_ready  input  1  downstream accept

## Operation
- Reset values: out_valid=0, out_data=0, out_chan=0, rr pointer last=CHANNELS-1.
- load = ~out_valid | out_ready. This means the output register is empty or is being drained this cycle.
- Grant, fixed mode (rr_en=0):
  - Grant channel sel if sel < CHANNELS and in_valid[sel]=1.
  - Otherwise there is no grant. An out-of-range sel never grants and never errors.
- Grant, round-robin mode (rr_en=1):
  - Scan the channels starting at (last+1) mod CHANNELS, wrapping around.
  - Grant the first channel with in_valid=1.
  - If no channel has in_valid=1, there is no grant.
- in_ready[g] = load & grant_valid for the granted channel g. All other in_ready bits are 0.
- On a cycle with load=1 and a grant:
  - out_data <= data of channel g.
  - out_chan <= g.
  - out_valid <= 1.
  - last <= g. The pointer updates in both modes, so a switch into round-robin continues fairly from the last served channel.
- On a cycle with load=1 and no grant, and out_ready=1: out_valid <= 0. out_data and out_chan hold their values.
- On a cycle with load=0 (out_valid=1, out_ready=0): the output register holds and all in_ready bits are 0.
- Simultaneous drain and refill in the same cycle is allowed. With every input valid, the block sustains one transfer per cycle.
- reset wins over every other input on the same edge. Any in-flight word is dropped, and in_ready is 0 while reset=1.
- rr_en and sel may change on any cycle. They affect only the grant computed in that cycle. A word already registered is unaffected.

## Timing
- Latency: an input accepted at edge N (in_valid & in_ready high before edge N) appears on out_data/out_valid right after edge N.
- in_ready depends combinationally on in_valid, sel, rr_en, out_valid and out_ready.
- in_ready has no combinational path from in_data.
- Outputs out_data, out_chan and out_valid come straight from registers.
- Handshake rules:
  - A transfer occurs on any edge where valid & ready are both 1.
  - Producers must hold in_data stable while in_valid=1 and in_ready=0.
  - While out_valid=1 and out_ready=0, out_data and out_chan are stable.
- Round-robin fairness: with all CHANNELS inputs continuously valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0,… with no channel starved longer than CHANNELS-1 transfers.

## Test plan
- Reset and idle:
  - Stimulus: assert reset with in_valid=4'b1111, then release it with in_valid=0.
  - Required: out_valid=0, out_data=0, out_chan=0, in_ready=0 during reset and afterwards.
- Fixed mode, WIDTH=8, CHANNELS=4:
  - Stimulus: rr_en=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1.
  - Required: in_ready=4'b0100 that cycle; next cycle out_data=8'hA5, out_chan=2, out_valid=1.
  - Then set sel=1 with ch1 invalid. Required: no grant, and out_valid drops to 0 one cycle later.
- Round-robin sweep:
  - Stimulus: rr_en=1, all valid, ch0..ch3 data = 8'h10/8'h20/8'h30/8'h40, out_ready=1.
  - Required: out_chan sequence 0,1,2,3,0 on consecutive cycles with matching data.
- Round-robin skip and wrap:
  - Stimulus: last=2, in_valid=4'b0011.
  - Required: grant ch0 (wraps past ch3), then ch1, then ch0.
- Backpressure:
  - Stimulus: out_valid=1 holding 8'h30, out_ready=0 for 3 cycles while all inputs are valid.
  - Required: in_ready=0 and out_data=8'h30 are stable. When out_ready rises, a new word is accepted in the same cycle.
- Reset mid-stream and bad select:
  - Stimulus: reset pulse while out_valid=1.
  - Required: out_valid=0 next cycle, and the first round-robin grant afterwards is ch0.
  - Stimulus: fixed mode with sel=3 and CHANNELS=3.
  - Required: no grant.
